// File: rtl/fetch_ifid.sv
// Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS core.
// A one-entry skid buffer parks a word that returns while decode is stalled.
module fetch_ifid #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    input  logic [31:0] PCJumpD,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic [31:0] PCD,
    output logic        ValidD
);

    typedef enum logic {
        FETCH = 1'b0,
        HELD  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic        redirect;
    logic [31:0] target;

    assign imem_req  = (state_q == FETCH) && rst_n;
    assign imem_addr = pcf_q;
    assign InstrD    = instr_q;
    assign PCPlus4D  = pcplus4_q;
    assign PCD       = pcd_q;
    assign ValidD    = valid_q;

    // Jump outranks branch; masking the low bits keeps PCF word aligned.
    assign redirect = (JumpD || PCSrcD) && !StallD;
    assign target   = (JumpD ? PCJumpD : PCBranchD) & 32'hFFFF_FFFC;

    always_comb begin
        // NOTE: every output of this block takes its hold value first, so no
        // path through the priority chain can leave one unassigned (no latch).
        state_d   = state_q;
        pcf_d     = pcf_q;
        instr_d   = instr_q;
        pcd_d     = pcd_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        skid_d    = skid_q;
        skid_pc_d = skid_pc_q;

        if (redirect) begin
            // The word returned this cycle is the delay slot and is squashed.
            pcf_d     = target;
            instr_d   = NOP_INSTR;
            valid_d   = 1'b0;
            skid_d    = '0;
            skid_pc_d = '0;
            state_d   = FETCH;
        end else if (state_q == FETCH && imem_ready && !StallD) begin
            instr_d   = imem_rdata;
            pcd_d     = pcf_q;
            pcplus4_d = pcf_q + 32'd4;
            valid_d   = 1'b1;
            pcf_d     = pcf_q + 32'd4;
        end else if (state_q == FETCH && imem_ready && StallD) begin
            skid_d    = imem_rdata;
            skid_pc_d = pcf_q;
            pcf_d     = pcf_q + 32'd4;
            state_d   = HELD;
        end else if (state_q == FETCH && !imem_ready && !StallD) begin
            instr_d   = NOP_INSTR;
            valid_d   = 1'b0;
        end else if (state_q == HELD && !StallD) begin
            instr_d   = skid_q;
            pcd_d     = skid_pc_q;
            pcplus4_d = skid_pc_q + 32'd4;
            valid_d   = 1'b1;
            state_d   = FETCH;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            pcf_q     <= RESET_PC;
            instr_q   <= NOP_INSTR;
            pcd_q     <= '0;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
            skid_q    <= '0;
            skid_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pcf_q     <= pcf_d;
            instr_q   <= instr_d;
            pcd_q     <= pcd_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
            skid_q    <= skid_d;
            skid_pc_q <= skid_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_ifid.sv
// Directed bench for fetch_ifid: a table of per-cycle vectors for the main
// instance, plus hand sequences for async reset in HELD and PC wrap-around.
module tb_fetch_ifid;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ready, StallD, PCSrcD, JumpD;
    logic [31:0] PCBranchD, PCJumpD;

    logic        req, req_hi;
    logic [31:0] addr, addr_hi, rdata, rdata_hi;
    logic [31:0] instr, instr_hi, pcp4, pcp4_hi, pcd, pcd_hi;
    logic        valid, valid_hi;

    int n_cmp  = 0;
    int n_fail = 0;

    // Memory model: the word at address a is a ^ 32'hA5A5_0000.
    assign rdata    = addr    ^ 32'hA5A5_0000;
    assign rdata_hi = addr_hi ^ 32'hA5A5_0000;

    always #5 clk = ~clk;

    fetch_ifid dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req), .imem_addr(addr), .imem_rdata(rdata), .imem_ready(imem_ready),
        .StallD(StallD), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
        .JumpD(JumpD), .PCJumpD(PCJumpD),
        .InstrD(instr), .PCPlus4D(pcp4), .PCD(pcd), .ValidD(valid)
    );

    fetch_ifid #(.RESET_PC(32'hFFFF_FFF8)) dut_hi (
        .clk(clk), .rst_n(rst_n),
        .imem_req(req_hi), .imem_addr(addr_hi), .imem_rdata(rdata_hi), .imem_ready(imem_ready),
        .StallD(StallD), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
        .JumpD(JumpD), .PCJumpD(PCJumpD),
        .InstrD(instr_hi), .PCPlus4D(pcp4_hi), .PCD(pcd_hi), .ValidD(valid_hi)
    );

    typedef struct {
        logic        ready, stall, pcsrc, jump;
        logic [31:0] branch, jtgt;
        logic        e_req;
        logic [31:0] e_addr, e_instr, e_pcd, e_p4;
        logic        e_valid;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic check_main(input string tag, input logic e_req, input logic [31:0] e_addr,
                              input logic [31:0] e_instr, input logic [31:0] e_pcd,
                              input logic [31:0] e_p4, input logic e_valid);
        check({tag, " req"},   {31'd0, req},   {31'd0, e_req});
        check({tag, " addr"},  addr,           e_addr);
        check({tag, " instr"}, instr,          e_instr);
        check({tag, " pcd"},   pcd,            e_pcd);
        check({tag, " pcp4"},  pcp4,           e_p4);
        check({tag, " valid"}, {31'd0, valid}, {31'd0, e_valid});
    endtask

    task automatic check_hi(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic [31:0] e_instr, input logic [31:0] e_pcd,
                            input logic [31:0] e_p4, input logic e_valid);
        check({tag, " hi req"},   {31'd0, req_hi},   {31'd0, e_req});
        check({tag, " hi addr"},  addr_hi,           e_addr);
        check({tag, " hi instr"}, instr_hi,          e_instr);
        check({tag, " hi pcd"},   pcd_hi,            e_pcd);
        check({tag, " hi pcp4"},  pcp4_hi,           e_p4);
        check({tag, " hi valid"}, {31'd0, valid_hi}, {31'd0, e_valid});
    endtask

    task automatic drive(input logic rdy, input logic stl, input logic bsrc, input logic jmp,
                         input logic [31:0] btgt, input logic [31:0] jtgt);
        imem_ready = rdy;
        StallD     = stl;
        PCSrcD     = bsrc;
        JumpD      = jmp;
        PCBranchD  = btgt;
        PCJumpD    = jtgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Fields: ready stall pcsrc jump branch jtgt | req addr instr pcd pcp4 valid
        // Streaming fetch.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h4,   32'hA5A5_0000, 32'h0,   32'h4,   1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h8,   32'hA5A5_0004, 32'h4,   32'h8,   1'b1};
        // Memory not ready for two cycles at PCF=0x8.
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h8,   32'h0,         32'h4,   32'h8,   1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h8,   32'h0,         32'h4,   32'h8,   1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hC,   32'hA5A5_0008, 32'h8,   32'hC,   1'b1};
        // Stall while word @0xC arrives: it goes to the skid buffer.
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h10,  32'hA5A5_0008, 32'h8,   32'hC,   1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h10,  32'hA5A5_0008, 32'h8,   32'hC,   1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h10,  32'hA5A5_0008, 32'h8,   32'hC,   1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h10,  32'hA5A5_000C, 32'hC,   32'h10,  1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h14,  32'hA5A5_0010, 32'h10,  32'h14,  1'b1};
        // Branch at PCF=0x14: word @0x14 squashed.
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'h100, 32'h0,       32'h10,  32'h14,  1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h104, 32'hA5A5_0100, 32'h100, 32'h104, 1'b1};
        // Branch under stall ignored (word @0x104 skidded), then jump beats branch.
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 32'h108, 32'hA5A5_0100, 32'h100, 32'h104, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h400, 1'b1, 32'h400, 32'h0,     32'h100, 32'h104, 1'b0};
        // Misaligned jump target is forced to a word boundary.
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h503, 1'b1, 32'h500, 32'h0,       32'h100, 32'h104, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h504, 32'hA5A5_0500, 32'h500, 32'h504, 1'b1};
        // Stall with memory not ready: everything holds.
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h504, 32'hA5A5_0500, 32'h500, 32'h504, 1'b1};

        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #12;
        check_main("in reset", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        check_hi("in reset", 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h0, 32'h0, 1'b0);
        #5 rst_n = 1'b1;
        #1;
        check_main("post reset", 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].ready, vecs[i].stall, vecs[i].pcsrc, vecs[i].jump,
                  vecs[i].branch, vecs[i].jtgt);
            tick();
            check_main($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_instr,
                       vecs[i].e_pcd, vecs[i].e_p4, vecs[i].e_valid);
        end

        // Enter HELD with word @0x504 parked, then reset asynchronously mid-cycle.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check_main("held", 1'b0, 32'h508, 32'hA5A5_0500, 32'h500, 32'h504, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_main("async rst", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        check_hi("async rst", 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h0, 32'h0, 1'b0);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_hi("hi start", 1'b1, 32'hFFFF_FFF8, 32'h0, 32'h0, 32'h0, 1'b0);

        // Held word is gone: main restarts from 0; hi wraps past 2^32.
        tick();
        check_main("restart0", 1'b1, 32'h4, 32'hA5A5_0000, 32'h0, 32'h4, 1'b1);
        check_hi("wrap0", 1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b1);
        tick();
        check_main("restart1", 1'b1, 32'h8, 32'hA5A5_0004, 32'h4, 32'h8, 1'b1);
        check_hi("wrap1", 1'b1, 32'h0, 32'h5A5A_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1);
        tick();
        check_hi("wrap2", 1'b1, 32'h4, 32'hA5A5_0000, 32'h0, 32'h4, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
